// File: rtl/mtimer_pkg.sv
// Shared register map and channel mode encoding for the multi-channel machine timer.
package mtimer_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'd0;
  localparam logic [7:0] ADDR_MTIME_L = 8'd1;
  localparam logic [7:0] ADDR_MTIME_H = 8'd2;
  localparam logic [7:0] ADDR_STATUS  = 8'd3;

  localparam int CH_BASE   = 8;
  localparam int CH_STRIDE = 4;

  localparam logic [1:0] CH_CMP_L  = 2'd0;
  localparam logic [1:0] CH_CMP_H  = 2'd1;
  localparam logic [1:0] CH_PERIOD = 2'd2;
  localparam logic [1:0] CH_MODE   = 2'd3;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_LEVEL    = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_PERIODIC = 2'b11
  } mode_e;

endpackage

// File: rtl/mtimer_cmp_channel.sv
// One compare channel: compare value, reload period, mode and sticky pending flag.
module mtimer_cmp_channel
  import mtimer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] mtime,
  input  logic [WIDTH-1:0] mtime_next,
  input  logic             inc,
  input  logic             wr_cmp_l,
  input  logic             wr_cmp_h,
  input  logic             wr_period,
  input  logic             wr_mode,
  input  logic [31:0]      wr_data,
  input  logic             w1c,
  output logic             pending,
  output logic [WIDTH-1:0] cmp,
  output logic [31:0]      period,
  output logic [1:0]       mode
);

  mode_e            mode_reg;
  logic [WIDTH-1:0] cmp_reg;
  logic [31:0]      period_reg;
  logic             pending_reg;
  logic             event_mode;
  logic             match;

  assign event_mode = (mode_reg == MODE_ONESHOT) || (mode_reg == MODE_PERIODIC);

  // A register write to this channel's compare or mode overrides a coincident match.
  assign match = inc && event_mode && (mtime_next == cmp_reg)
               && !(wr_cmp_l || wr_cmp_h || wr_mode);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cmp_reg     <= '1;
      period_reg  <= '0;
      mode_reg    <= MODE_OFF;
      pending_reg <= 1'b0;
    end else begin
      if (wr_cmp_l)
        cmp_reg[31:0] <= wr_data;
      else if (wr_cmp_h)
        cmp_reg[WIDTH-1:32] <= wr_data[WIDTH-33:0];
      else if (match && mode_reg == MODE_PERIODIC)
        cmp_reg <= cmp_reg + WIDTH'(period_reg);

      if (wr_period)
        period_reg <= wr_data;

      if (wr_mode)
        mode_reg <= mode_e'(wr_data[1:0]);
      else if (match && mode_reg == MODE_ONESHOT)
        mode_reg <= MODE_OFF;

      if (wr_mode && mode_e'(wr_data[1:0]) == MODE_LEVEL)
        pending_reg <= 1'b0;
      else if (match)
        pending_reg <= 1'b1;
      else if (w1c)
        pending_reg <= 1'b0;
    end
  end

  // LEVEL mode bypasses the sticky flag and follows the compare directly.
  assign pending = (mode_reg == MODE_LEVEL) ? (mtime >= cmp_reg) : pending_reg;
  assign cmp     = cmp_reg;
  assign period  = period_reg;
  assign mode    = mode_reg;

endmodule

// File: rtl/mtimer_multi.sv
// Machine timer top: CTRL, prescaler, free-running mtime, register decode and
// read mux, with NUM_CMP compare channels.
module mtimer_multi
  import mtimer_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NUM_CMP = 4,
  parameter int PRESC_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               wr_en,
  input  logic [7:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic [7:0]         rd_addr,
  output logic [31:0]        rd_data,
  output logic [31:0]        mtime_h,
  output logic [31:0]        mtime_l,
  output logic [NUM_CMP-1:0] timer_int,
  output logic               timer_int_any
);

  logic               en_reg;
  logic [PRESC_W-1:0] prescale_reg;
  logic [PRESC_W-1:0] pcnt_reg;
  logic [WIDTH-1:0]   mtime_reg;
  logic [WIDTH-1:0]   mtime_next;
  logic               tick;
  logic               inc;
  logic               wr_ctrl, wr_mtime_l, wr_mtime_h, wr_status;

  logic [NUM_CMP-1:0] pending;
  logic [WIDTH-1:0]   cmp_arr    [NUM_CMP];
  logic [31:0]        period_arr [NUM_CMP];
  logic [1:0]         mode_arr   [NUM_CMP];
  logic [63:0]        pending_ext;

  assign wr_ctrl    = wr_en && (wr_addr == ADDR_CTRL);
  assign wr_mtime_l = wr_en && (wr_addr == ADDR_MTIME_L);
  assign wr_mtime_h = wr_en && (wr_addr == ADDR_MTIME_H);
  assign wr_status  = wr_en && (wr_addr == ADDR_STATUS);

  assign tick = en_reg && (pcnt_reg == prescale_reg);

  // A software write to either mtime half takes priority over the tick increment.
  always_comb begin
    mtime_next = mtime_reg;
    inc        = 1'b0;
    if (wr_mtime_l)
      mtime_next[31:0] = wr_data;
    else if (wr_mtime_h)
      mtime_next[WIDTH-1:32] = wr_data[WIDTH-33:0];
    else if (tick) begin
      mtime_next = mtime_reg + WIDTH'(1);
      inc        = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      en_reg       <= 1'b0;
      prescale_reg <= '0;
      pcnt_reg     <= '0;
      mtime_reg    <= '0;
    end else begin
      mtime_reg <= mtime_next;
      if (wr_ctrl) begin
        en_reg       <= wr_data[0];
        prescale_reg <= wr_data[PRESC_W+15:16];
        pcnt_reg     <= '0;
      end else if (!en_reg || tick)
        pcnt_reg <= '0;
      else
        pcnt_reg <= pcnt_reg + PRESC_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_CMP; gi++) begin : g_ch
    localparam logic [7:0] BASE = 8'(CH_BASE + CH_STRIDE * gi);
    logic ch_hit;
    logic w1c;

    assign ch_hit = wr_en && (wr_addr[7:2] == BASE[7:2]);

    // STATUS is 32 bits wide; channels beyond bit 31 cannot be cleared through it.
    if (gi < 32) begin : g_w1c
      assign w1c = wr_status && wr_data[gi];
    end else begin : g_no_w1c
      assign w1c = 1'b0;
    end

    mtimer_cmp_channel #(.WIDTH(WIDTH)) u_ch (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .mtime      (mtime_reg),
      .mtime_next (mtime_next),
      .inc        (inc),
      .wr_cmp_l   (ch_hit && wr_addr[1:0] == CH_CMP_L),
      .wr_cmp_h   (ch_hit && wr_addr[1:0] == CH_CMP_H),
      .wr_period  (ch_hit && wr_addr[1:0] == CH_PERIOD),
      .wr_mode    (ch_hit && wr_addr[1:0] == CH_MODE),
      .wr_data    (wr_data),
      .w1c        (w1c),
      .pending    (pending[gi]),
      .cmp        (cmp_arr[gi]),
      .period     (period_arr[gi]),
      .mode       (mode_arr[gi])
    );
  end

  assign pending_ext = 64'(pending);

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_CTRL: begin
        rd_data[0]                = en_reg;
        rd_data[PRESC_W+15:16]    = prescale_reg;
      end
      ADDR_MTIME_L: rd_data = mtime_l;
      ADDR_MTIME_H: rd_data = mtime_h;
      ADDR_STATUS:  rd_data = pending_ext[31:0];
      default: begin
        for (int c = 0; c < NUM_CMP; c++) begin
          if (rd_addr[7:2] == 6'(CH_BASE / CH_STRIDE + c)) begin
            case (rd_addr[1:0])
              CH_CMP_L:  rd_data = cmp_arr[c][31:0];
              CH_CMP_H:  rd_data = 32'(cmp_arr[c][WIDTH-1:32]);
              CH_PERIOD: rd_data = period_arr[c];
              default:   rd_data = {30'd0, mode_arr[c]};
            endcase
          end
        end
      end
    endcase
  end

  assign mtime_l       = mtime_reg[31:0];
  assign mtime_h       = 32'(mtime_reg[WIDTH-1:32]);
  assign timer_int     = pending;
  assign timer_int_any = |pending;

endmodule

// File: tb/tb_mtimer_multi.sv
// Bench for mtimer_multi: directed scenarios plus random register traffic,
// all outputs compared every cycle against a behavioural model.
module tb_mtimer_multi;

  localparam int WIDTH   = 64;
  localparam int NUM_CMP = 4;
  localparam int PRESC_W = 16;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               wr_en = 1'b0;
  logic [7:0]         wr_addr = 8'd0;
  logic [31:0]        wr_data = 32'd0;
  logic [7:0]         rd_addr = 8'd0;
  logic [31:0]        rd_data;
  logic [31:0]        mtime_h;
  logic [31:0]        mtime_l;
  logic [NUM_CMP-1:0] timer_int;
  logic               timer_int_any;

  mtimer_multi #(.WIDTH(WIDTH), .NUM_CMP(NUM_CMP), .PRESC_W(PRESC_W)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .mtime_h       (mtime_h),
    .mtime_l       (mtime_l),
    .timer_int     (timer_int),
    .timer_int_any (timer_int_any)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit        m_en;
  bit [15:0] m_presc, m_pcnt;
  bit [63:0] m_mtime;
  bit [63:0] m_cmp    [NUM_CMP];
  bit [31:0] m_per    [NUM_CMP];
  bit [1:0]  m_mode   [NUM_CMP];
  bit        m_sticky [NUM_CMP];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model_reset();
    m_en = 0; m_presc = 0; m_pcnt = 0; m_mtime = 0;
    for (int c = 0; c < NUM_CMP; c++) begin
      m_cmp[c] = '1; m_per[c] = 0; m_mode[c] = 0; m_sticky[c] = 0;
    end
  endfunction

  function automatic bit model_pending(int c);
    return (m_mode[c] == 2'd1) ? (m_mtime >= m_cmp[c]) : m_sticky[c];
  endfunction

  function automatic bit [31:0] model_read(bit [7:0] a);
    bit [31:0] r = 0;
    if (a == 0) r = {m_presc, 15'd0, m_en};
    else if (a == 1) r = m_mtime[31:0];
    else if (a == 2) r = m_mtime[63:32];
    else if (a == 3) begin
      for (int c = 0; c < NUM_CMP; c++) r[c] = model_pending(c);
    end else if (a >= 8 && a < 8 + 4 * NUM_CMP) begin
      int c = (int'(a) - 8) / 4;
      case ((int'(a) - 8) % 4)
        0:       r = m_cmp[c][31:0];
        1:       r = m_cmp[c][63:32];
        2:       r = m_per[c];
        default: r = {30'd0, m_mode[c]};
      endcase
    end
    return r;
  endfunction

  // Advance the model by one clock edge given that cycle's bus write.
  function automatic void model_step(bit we, bit [7:0] a, bit [31:0] d);
    bit tick, inc, hit, match;
    bit [63:0] nt;
    int off;
    tick = m_en && (m_pcnt == m_presc);
    if (we && a == 0) begin m_en = d[0]; m_presc = d[31:16]; m_pcnt = 0; end
    else if (!m_en || tick) m_pcnt = 0;
    else m_pcnt = m_pcnt + 1;
    nt = m_mtime; inc = 0;
    if (we && a == 1) nt[31:0] = d;
    else if (we && a == 2) nt[63:32] = d;
    else if (tick) begin nt = m_mtime + 1; inc = 1; end
    for (int c = 0; c < NUM_CMP; c++) begin
      hit   = we && (int'(a) >= 8 + 4 * c) && (int'(a) < 12 + 4 * c);
      off   = int'(a) - (8 + 4 * c);
      match = inc && (m_mode[c] >= 2) && (nt == m_cmp[c]) && !(hit && off != 2);
      if (match) begin
        m_sticky[c] = 1;
        if (m_mode[c] == 2) m_mode[c] = 0;
        else m_cmp[c] = m_cmp[c] + 64'(m_per[c]);
      end
      if (we && a == 3 && d[c] && !match) m_sticky[c] = 0;
      if (hit) begin
        case (off)
          0: m_cmp[c][31:0]  = d;
          1: m_cmp[c][63:32] = d;
          2: m_per[c]        = d;
          default: begin
            m_mode[c] = d[1:0];
            if (d[1:0] == 2'd1) m_sticky[c] = 0;
          end
        endcase
      end
    end
    m_mtime = nt;
  endfunction

  task automatic cycle(bit we, bit [7:0] a, bit [31:0] d, bit [7:0] ra);
    bit [NUM_CMP-1:0] e;
    @(negedge CLK);
    wr_en = we; wr_addr = a; wr_data = d; rd_addr = ra;
    #1;
    for (int c = 0; c < NUM_CMP; c++) e[c] = model_pending(c);
    check("mtime_l", mtime_l, m_mtime[31:0]);
    check("mtime_h", mtime_h, m_mtime[63:32]);
    check("timer_int", timer_int, e);
    check("timer_int_any", timer_int_any, |e);
    check($sformatf("rd_data@%0d", ra), rd_data, model_read(ra));
    @(posedge CLK);
    model_step(we, a, d);
  endtask

  task automatic do_reset(bit inflight);
    @(negedge CLK);
    RST_N = 0; wr_en = inflight; wr_addr = 8'd0; wr_data = 32'h0003_0001; rd_addr = 8'd3;
    @(posedge CLK);
    @(posedge CLK);
    model_reset();
    #1;
    RST_N = 1; wr_en = 0;
  endtask

  task automatic rand_cycle();
    bit we; bit [7:0] a, ra; bit [31:0] d; int c;
    we = ($urandom_range(0, 3) == 0);
    c  = $urandom_range(0, NUM_CMP - 1);
    a  = 0; d = $urandom;
    case ($urandom_range(0, 11))
      0: d = {16'($urandom_range(0, 3)), 15'd0, 1'($urandom_range(0, 7) != 0)};
      1: begin a = 1; d = $urandom_range(0, 1) ? 32'($urandom_range(0, 40))
                                              : 32'hffff_fff0 + 32'($urandom_range(0, 15)); end
      2: begin a = 2; d = $urandom_range(0, 1) ? 32'd0 : 32'hffff_ffff; end
      3: a = 3;
      4, 5: begin a = 8'(8 + 4 * c); d = m_mtime[31:0] + 32'($urandom_range(0, 20)); end
      6: begin a = 8'(9 + 4 * c); d = ($urandom_range(0, 7) == 0) ? $urandom : m_mtime[63:32]; end
      7: begin a = 8'(10 + 4 * c); d = 32'($urandom_range(0, 12)); end
      8, 9: begin a = 8'(11 + 4 * c); d = 32'($urandom_range(0, 3)); end
      10: a = $urandom_range(0, 1) ? 8'($urandom_range(4, 7)) : 8'($urandom_range(24, 255));
      default: we = 0;
    endcase
    ra = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 27));
    cycle(we, a, d, ra);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a write in flight; it must be discarded.
    do_reset(1);
    #1;
    check("rst_mtime_l", mtime_l, 32'd0);
    check("rst_timer_int", timer_int, 0);
    check("rst_any", timer_int_any, 0);
    check("rst_status", rd_data, 32'd0);

    // Enable with prescale 0: mtime 0,1,2
    cycle(1, 8'd0, 32'd1, 8'd1);
    #1 check("cnt0", mtime_l, 32'd0);
    cycle(0, 8'd0, 32'd0, 8'd1);
    #1 check("cnt1", mtime_l, 32'd1);
    cycle(0, 8'd0, 32'd0, 8'd3);
    #1 check("cnt2", mtime_l, 32'd2);

    // Prescale 3 with a CTRL rewrite mid-count
    cycle(1, 8'd0, 32'h0003_0001, 8'd0);
    for (int i = 0; i < 6; i++) cycle(0, 8'd0, 32'd0, 8'd1);
    cycle(1, 8'd0, 32'h0003_0001, 8'd0);
    for (int i = 0; i < 10; i++) cycle(0, 8'd0, 32'd0, 8'd1);

    // ch0 LEVEL at cmp=10
    cycle(1, 8'd0, 32'd0, 8'd0);
    cycle(1, 8'd1, 32'd0, 8'd1);
    cycle(1, 8'd2, 32'd0, 8'd2);
    cycle(1, 8'd9, 32'd0, 8'd9);
    cycle(1, 8'd8, 32'd10, 8'd8);
    cycle(1, 8'd11, 32'd1, 8'd11);
    cycle(1, 8'd0, 32'd1, 8'd3);
    for (int i = 0; i < 40 && m_mtime < 12; i++) cycle(0, 8'd0, 32'd0, 8'd3);
    cycle(1, 8'd3, 32'd1, 8'd3);
    #1 check("lvl_w1c_hold", timer_int[0], 1'b1);
    cycle(1, 8'd8, 32'd20, 8'd8);
    #1 check("lvl_drop", timer_int[0], 1'b0);

    // ch1 ONESHOT at cmp=5
    cycle(1, 8'd0, 32'd0, 8'd0);
    cycle(1, 8'd1, 32'd0, 8'd1);
    cycle(1, 8'd13, 32'd0, 8'd13);
    cycle(1, 8'd12, 32'd5, 8'd12);
    cycle(1, 8'd15, 32'd2, 8'd15);
    cycle(1, 8'd0, 32'd1, 8'd15);
    for (int i = 0; i < 10; i++) cycle(0, 8'd0, 32'd0, 8'd15);
    #1 check("os_pend", timer_int[1], 1'b1);
    check("os_mode_off", rd_data, 32'd0);

    // ch2 PERIODIC cmp=4 period=6; W1C coincides with the match at 10
    cycle(1, 8'd0, 32'd0, 8'd0);
    cycle(1, 8'd1, 32'd0, 8'd1);
    cycle(1, 8'd17, 32'd0, 8'd17);
    cycle(1, 8'd16, 32'd4, 8'd16);
    cycle(1, 8'd18, 32'd6, 8'd18);
    cycle(1, 8'd19, 32'd3, 8'd19);
    cycle(1, 8'd0, 32'd1, 8'd16);
    for (int i = 0; i < 30 && m_mtime != 6; i++) cycle(0, 8'd0, 32'd0, 8'd16);
    cycle(1, 8'd3, 32'd4, 8'd16);
    for (int i = 0; i < 30 && m_mtime != 9; i++) cycle(0, 8'd0, 32'd0, 8'd16);
    #1 check("per_sync9", mtime_l, 32'd9);
    cycle(1, 8'd3, 32'd4, 8'd16);
    #1 check("per_set_wins", timer_int[2], 1'b1);
    check("per_mtime10", mtime_l, 32'd10);
    check("per_reload", rd_data, 32'd16);
    for (int i = 0; i < 8; i++) cycle(0, 8'd0, 32'd0, 8'd16);

    // Wrap: mtime all ones, ch3 ONESHOT cmp=0
    cycle(1, 8'd0, 32'd0, 8'd0);
    cycle(1, 8'd2, 32'hffff_ffff, 8'd2);
    cycle(1, 8'd1, 32'hffff_ffff, 8'd1);
    cycle(1, 8'd20, 32'd0, 8'd20);
    cycle(1, 8'd21, 32'd0, 8'd21);
    cycle(1, 8'd23, 32'd2, 8'd23);
    cycle(1, 8'd0, 32'd1, 8'd23);
    #1 check("wrap_top", mtime_l, 32'hffff_ffff);
    cycle(0, 8'd0, 32'd0, 8'd23);
    #1 check("wrap_int3", timer_int[3], 1'b1);
    check("wrap_any", timer_int_any, 1'b1);
    check("wrap_mtime_h", mtime_h, 32'd0);
    check("wrap_mtime_l", mtime_l, 32'd0);
    check("wrap_mode3", rd_data, 32'd0);

    // ch1 pending survived the wrap; W1C clears it
    check("os_sticky", timer_int[1], 1'b1);
    cycle(1, 8'd3, 32'd2, 8'd3);
    #1 check("os_w1c", timer_int[1], 1'b0);

    for (int i = 0; i < 3000; i++) rand_cycle();
    do_reset(1);
    for (int i = 0; i < 1000; i++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
